// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) master for command bytes.
//
// Bytes arrive on a valid/ready stream together with a frame-end flag. They are
// queued and shifted out MSB-first. SCLK half-period is CLK_DIV cycles of i_clk.
// Slave select stays low across a multi-byte frame until the byte flagged i_last
// has finished. MISO is shifted in on every SCLK rise. Each finished byte is
// returned on o_rx_data with a one-cycle o_rx_valid strobe.
//
// Build option:
//   SPI_MASTER_TX_FIFO_EN  defined   -> the queue is a 4-entry FIFO
//                          undefined -> the queue is a single holding register
//   Transfer timing is identical in both builds.
//
// Parameters:
//   CLK_DIV  SCLK half-period in i_clk cycles (>= 1)
//   SS_GAP   minimum GAP cycles with ss high between frames (>= 1)
//
// Ports:
//   i_clk       system clock (the only clock)
//   i_rst       synchronous reset, active-high; flushes the queue and aborts any frame
//   i_data      byte to transmit
//   i_last      this byte ends the frame
//   i_valid     i_data / i_last are valid
//   o_ready     queue can accept a byte; a byte transfers on i_valid && o_ready
//   o_spi_clk   SCLK, idles low
//   o_spi_mosi  serial data out, MSB first
//   i_spi_miso  serial data in
//   o_spi_ss    slave select, active-low
//   o_rx_data   byte captured from MISO
//   o_rx_valid  one-cycle strobe; o_rx_data was updated this cycle
//   o_busy      high while a frame is active or the queue holds a byte
module spi_master_tx #(
  parameter int unsigned CLK_DIV = 5,
  parameter int unsigned SS_GAP  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_ss,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy
);

  // One shared down-counter covers the SCLK half-period, HOLD and GAP.
  localparam int unsigned MaxCnt = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(SS_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StStall,
    StHold,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // Byte queue. Each entry is {last, data}.
  // ---------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic       q_full;
  logic       q_empty;
  logic       q_occ_d;  // queue holds at least one entry after this edge
  logic [8:0] q_head;

  // Reset holds o_ready low so no byte is accepted into a queue being flushed.
  assign o_ready = !q_full && !i_rst;
  assign push    = i_valid && o_ready;

`ifdef SPI_MASTER_TX_FIFO_EN
  logic [8:0] mem_q [4];
  logic [1:0] wr_q;
  logic [1:0] rd_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_q] <= {i_last, i_data};
    end
  end

  assign q_head  = mem_q[rd_q];
  assign q_full  = (cnt_q == 3'd4);
  assign q_empty = (cnt_q == 3'd0);
  assign q_occ_d = (cnt_d != 3'd0);
`else
  logic [8:0] hold_q;
  logic       full_q;
  logic       full_d;

  // push needs !full and pop needs full, so they never happen together here.
  always_comb begin
    full_d = full_q;
    if (push) begin
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      hold_q <= {i_last, i_data};
    end
  end

  assign q_head  = hold_q;
  assign q_full  = full_q;
  assign q_empty = !full_q;
  assign q_occ_d = full_d;
`endif

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;      // SCLK falls completed in the current byte
  logic [7:0]      tx_sh_q, tx_sh_d;  // bit 7 is the bit currently on MOSI
  logic            last_q, last_d;    // frame-end flag of the byte in flight
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ss_q, ss_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            busy_q, busy_d;
  logic            load;              // pop the queue head into the shifter

  assign pop = load;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    last_d     = last_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          load    = 1'b1;
          ss_d    = 1'b0;
          div_d   = '0;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], i_spi_miso};
          state_d = StShift;
        end else begin
          div_d = div_q + CntW'(1);
        end
      end

      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], i_spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d      = '0;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_sh_q;
              if (last_q) begin
                state_d = StHold;
              end else if (!q_empty) begin
                // Next byte's bit 7 goes out on this same fall: SCLK never pauses.
                load = 1'b1;
              end else begin
                state_d = StStall;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + CntW'(1);
        end
      end

      StStall: begin
        if (!q_empty) begin
          load    = 1'b1;
          div_d   = '0;
          state_d = StSetup;
        end
      end

      StHold: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = StGap;
        end else begin
          div_d = div_q + CntW'(1);
        end
      end

      StGap: begin
        if (div_q == GapLast) begin
          div_d   = '0;
          state_d = StIdle;
        end else begin
          div_d = div_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      tx_sh_d = q_head[7:0];
      last_d  = q_head[8];
      mosi_d  = q_head[7];
    end
  end

  // Registered so o_busy reflects the state and queue of the same cycle.
  always_comb begin
    busy_d = (state_d != StIdle) || q_occ_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      last_q     <= 1'b0;
      rx_sh_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      last_q     <= last_d;
      rx_sh_q    <= rx_sh_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_spi_clk  = sclk_q;
  assign o_spi_mosi = mosi_q;
  assign o_spi_ss   = ss_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx with CLK_DIV=5 and SS_GAP=2. MISO is looped back to MOSI.
// Expected rx bytes and their strobe cycles go into a queue when the stimulus is
// issued. A monitor pops the queue on every o_rx_valid and compares.
module tb_spi_master_tx;

`ifdef SPI_MASTER_TX_FIFO_EN
  localparam int ExpAccept = 5;
`else
  localparam int ExpAccept = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       last = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  assign miso = mosi;

  spi_master_tx #(
    .CLK_DIV(5),
    .SS_GAP (2)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (data),
    .i_last    (last),
    .i_valid   (valid),
    .o_ready   (ready),
    .o_spi_clk (sclk),
    .o_spi_mosi(mosi),
    .i_spi_miso(miso),
    .o_spi_ss  (ss),
    .o_rx_data (rx_data),
    .o_rx_valid(rx_valid),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    int data;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin : rx_monitor
    exp_t e;
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: strobe with data 0x%0h, expected no strobe (cycle %0d)",
                 rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", int'(rx_data), e.data);
        check("rx_cycle", cyc, e.cyc);
      end
    end
  end

  // Edge recorders for SCLK rises and ss rises.
  int   rise_q[$];
  int   ss_rise_q[$];
  logic sclk_prev = 1'b0;
  logic ss_prev = 1'b1;

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev === 1'b0) rise_q.push_back(cyc);
    if (ss === 1'b1 && ss_prev === 1'b0) ss_rise_q.push_back(cyc);
    sclk_prev = sclk;
    ss_prev   = ss;
  end

  function automatic int rises_in(input int lo, input int hi);
    int n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo && rise_q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int ss_rises_in(input int lo, input int hi);
    int n = 0;
    foreach (ss_rise_q[i]) if (ss_rise_q[i] >= lo && ss_rise_q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int bad_gaps(input int lo, input int hi, input int gap);
    int n = 0;
    int prev = -1;
    foreach (rise_q[i]) begin
      if (rise_q[i] >= lo && rise_q[i] <= hi) begin
        if (prev >= 0 && rise_q[i] - prev != gap) n++;
        prev = rise_q[i];
      end
    end
    return n;
  endfunction

  function automatic int first_rise_from(input int lo);
    int r = -1;
    foreach (rise_q[i]) if (r < 0 && rise_q[i] >= lo) r = rise_q[i];
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offer one byte; returns the handshake cycle. Caller is aligned just after a posedge.
  task automatic send(input logic [7:0] d, input logic l, output int hs);
    int budget = 1000;
    hs    = -1;
    data  = d;
    last  = l;
    valid = 1'b1;
    while (hs < 0 && budget > 0) begin
      if (ready) hs = cyc;
      sync();
      budget--;
    end
    valid = 1'b0;
    if (hs < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected a handshake", d);
    end
  endtask

  task automatic wait_idle();
    int budget = 3000;
    while (busy !== 1'b0 && budget > 0) begin
      sync();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %0b, expected 0", busy);
    end
    repeat (3) sync();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    int hs;
    int idx;
    int early;
    int base;
    int a5;
    logic [7:0] vals [6];
    vals = '{8'h3C, 8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hF0};
    a5   = 8'hA5;

    // Reset
    repeat (3) sync();
    check("ready_in_reset", int'(ready), 0);
    rst = 1'b0;
    #1;
    check("rst_ss", int'(ss), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(ready), 1);

    // Single byte 0xA5, last
    sync();
    send(8'hA5, 1'b1, t0);
    exp_q.push_back('{data: 8'hA5, cyc: t0 + 82});
    wait_cyc(t0 + 1);
    check("a5_ss_c1", int'(ss), 1);
    wait_cyc(t0 + 2);
    check("a5_ss_c2", int'(ss), 0);
    check("a5_mosi_c2", int'(mosi), 1);
    wait_cyc(t0 + 6);
    check("a5_sclk_before_rise", int'(sclk), 0);
    for (int j = 0; j < 8; j++) begin
      wait_cyc(t0 + 7 + 10 * j);
      check("a5_sclk_rise", int'(sclk), 1);
      check("a5_mosi_bit", int'(mosi), (a5 >> (7 - j)) & 1);
    end
    wait_cyc(t0 + 86);
    check("a5_ss_c86", int'(ss), 0);
    wait_cyc(t0 + 87);
    check("a5_ss_c87", int'(ss), 1);
    wait_idle();

    // Three-byte frame, continuous SCLK
    sync();
    send(8'h01, 1'b0, t0);
    exp_q.push_back('{data: 8'h01, cyc: t0 + 82});
    exp_q.push_back('{data: 8'h02, cyc: t0 + 162});
    exp_q.push_back('{data: 8'h03, cyc: t0 + 242});
    send(8'h02, 1'b0, hs);
    send(8'h03, 1'b1, hs);
    wait_cyc(t0 + 250);
    check("frame3_rises", rises_in(t0, t0 + 250), 24);
    check("frame3_bad_gaps", bad_gaps(t0, t0 + 250, 10), 0);
    check("frame3_ss_glitch", ss_rises_in(t0 + 3, t0 + 246), 0);
    check("frame3_ss_end", ss_rises_in(t0 + 247, t0 + 247), 1);
    wait_idle();

    // Underrun: STALL between two bytes of one frame
    sync();
    send(8'h10, 1'b0, t0);
    exp_q.push_back('{data: 8'h10, cyc: t0 + 82});
    wait_cyc(t0 + 120);
    check("stall_sclk", int'(sclk), 0);
    check("stall_ss", int'(ss), 0);
    check("stall_busy", int'(busy), 1);
    wait_cyc(t0 + 200);
    send(8'h20, 1'b1, t1);
    exp_q.push_back('{data: 8'h20, cyc: t1 + 82});
    wait_cyc(t1 + 90);
    check("stall_first_rise", first_rise_from(t0 + 83), t1 + 7);
    check("stall_ss_glitch", ss_rises_in(t0 + 3, t1 + 86), 0);
    check("stall_ss_end", ss_rises_in(t1 + 87, t1 + 87), 1);
    wait_idle();

    // Held valid with six bytes
    sync();
    t0 = cyc;
    for (int k = 0; k < 6; k++) exp_q.push_back('{data: int'(vals[k]), cyc: t0 + 82 + 80 * k});
    idx   = 0;
    early = 0;
    while (idx < 6 && cyc < t0 + 1000) begin
      valid = 1'b1;
      data  = vals[idx];
      last  = (idx == 5);
      if (ready) begin
        if (cyc < t0 + 20) early++;
        idx++;
      end
      sync();
    end
    valid = 1'b0;
    check("burst_early_accepts", early, ExpAccept);
    check("burst_total_accepts", idx, 6);
    wait_idle();

    // Reset mid-frame
    sync();
    t0  = cyc;
    idx = 0;
    while (cyc < t0 + 40) begin
      if (idx < 3) begin
        valid = 1'b1;
        data  = 8'hE0 + 8'(idx);
        last  = (idx == 2);
        if (ready) idx++;
      end else begin
        valid = 1'b0;
      end
      sync();
    end
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", int'(ready), 0);
    sync();
    rst = 1'b0;
    #1;
    check("midrst_ss", int'(ss), 1);
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_mosi", int'(mosi), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_ready", int'(ready), 1);
    base = cyc;
    wait_cyc(base + 100);
    check("midrst_no_sclk", rises_in(base, base + 100), 0);
    check("midrst_still_idle", int'(busy), 0);

    // Two single-byte frames: ss gap
    sync();
    send(8'h81, 1'b1, t0);
    exp_q.push_back('{data: 8'h81, cyc: t0 + 82});
    exp_q.push_back('{data: 8'h7E, cyc: t0 + 170});
    send(8'h7E, 1'b1, hs);
    wait_cyc(t0 + 86);
    check("gap_ss_c86", int'(ss), 0);
    wait_cyc(t0 + 87);
    check("gap_ss_c87", int'(ss), 1);
    wait_cyc(t0 + 88);
    check("gap_ss_c88", int'(ss), 1);
    wait_cyc(t0 + 89);
    check("gap_ss_c89", int'(ss), 1);
    wait_cyc(t0 + 90);
    check("gap_ss_c90", int'(ss), 0);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
